// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - rotating-priority grant search over N requesters
module rr_grant #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [2*N-1:0] req2;

    // Search {req, req} upward from ptr; the lower copy below ptr is masked so
    // the upper copy supplies the wrapped-around candidates.
    always_comb begin
        req2    = {req, req};
        any     = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int k = 2*N-1; k >= 0; k--) begin
            if (req2[k] && (k >= int'(ptr))) begin
                any     = 1'b1;
                gnt_idx = (k >= N) ? SEL_W'(k - N) : SEL_W'(k);
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - round-robin arbitrating mux with registered output stage
module rr_arb_mux #(
    parameter int WIDTH = 4,
    parameter int N     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           in_valid,
    input  logic [N*WIDTH-1:0]     in_data,
    output logic [N-1:0]           in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_sel,
    input  logic                   out_ready
);

    localparam int SEL_W = $clog2(N);

    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             any;
    logic             load;
    logic [WIDTH-1:0] sel_data;

    rr_grant #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_grant (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign load     = !out_valid || out_ready;
    assign in_ready = (!rst && load && any) ? gnt : '0;

    // One-hot data select driven by the grant vector.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= gnt_idx;
                ptr       <= (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - scoreboard bench for rr_arb_mux (N=4 and N=3 instances)
module tb_rr_arb_mux;

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    logic [2:0]  in_valid3;
    logic [11:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [3:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_ready3;

    exp_t q4[$];
    exp_t q3[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(4), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    rr_arb_mux #(.WIDTH(4), .N(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_ready (out_ready3)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: each output transfer pops the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                check("n4_unexpected_word", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("n4_out_data", int'(out_data), int'(e.d));
                check("n4_out_sel", int'(out_sel), int'(e.s));
            end
        end
        if (!rst && out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
                check("n3_unexpected_word", 1, 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("n3_out_data", int'(out_data3), int'(e.d));
                check("n3_out_sel", int'(out_sel3), int'(e.s));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 4'hF;
        in_data    = 16'h8765;
        out_ready  = 1'b1;
        in_valid3  = 3'b111;
        in_data3   = 12'h765;
        out_ready3 = 1'b1;
        step();
        step();
        // Reset state
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sel", int'(out_sel), 0);
        check("rst_in_ready3", int'(in_ready3), 0);
        in_valid3 = 3'b000;

        // First grant after release goes to channel 0
        rst      = 1'b0;
        in_valid = 4'b0001;
        in_data  = 16'h0003;
        #1;
        check("first_grant", int'(in_ready), 4'b0001);
        q4.push_back('{d: 4'h3, s: 2'd0});
        step();

        // Single channel 2, then search continues from channel 3
        in_valid = 4'b0100;
        in_data  = 16'h0A00;
        #1;
        check("single_ready", int'(in_ready), 4'b0100);
        q4.push_back('{d: 4'hA, s: 2'd2});
        step();
        check("single_latency_valid", int'(out_valid), 1);
        in_valid = 4'b1100;
        in_data  = 16'hCB00;
        #1;
        check("after_single_ready", int'(in_ready), 4'b1000);
        q4.push_back('{d: 4'hC, s: 2'd3});
        step();

        // Full contention, data = index + 5
        in_valid = 4'hF;
        in_data  = 16'h8765;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("contention_ready", int'(in_ready), 1 << (k % 4));
            q4.push_back('{d: 4'(k % 4 + 5), s: 2'(k % 4)});
            step();
        end

        // Backpressure with channel 1's word held
        in_valid = 4'b0010;
        #1;
        check("bp_load_ready", int'(in_ready), 4'b0010);
        q4.push_back('{d: 4'h6, s: 2'd1});
        step();
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'(out_data), 6);
            check("bp_out_sel", int'(out_sel), 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", int'(in_ready), 4'b0100);
        q4.push_back('{d: 4'h7, s: 2'd2});
        step();
        check("bp_no_bubble", int'(out_valid), 1);

        // Skip and wrap: ptr=3, only channel 1 valid
        in_valid = 4'b0010;
        #1;
        check("wrap_ready", int'(in_ready), 4'b0010);
        q4.push_back('{d: 4'h6, s: 2'd1});
        step();
        in_valid = 4'b0000;
        #1;
        check("idle_ready", int'(in_ready), 0);
        step();
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_out_sel_hold", int'(out_sel), 1);
        check("idle_out_data_hold", int'(out_data), 6);
        in_valid = 4'hF;
        #1;
        check("ptr_hold_ready", int'(in_ready), 4'b0100);
        q4.push_back('{d: 4'h7, s: 2'd2});
        step();
        in_valid = 4'b0000;
        step();

        // Reset mid-operation discards a held word
        in_valid = 4'b0001;
        #1;
        check("mid_load_ready", int'(in_ready), 4'b0001);
        step();
        out_ready = 1'b0;
        in_valid  = 4'hF;
        rst       = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        step();
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_sel", int'(out_sel), 0);
        check("mid_rst_out_data", int'(out_data), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_ready", int'(in_ready), 4'b0001);
        q4.push_back('{d: 4'h5, s: 2'd0});
        step();
        in_valid = 4'b0000;
        step();

        // Non-power-of-two N=3, all valid
        in_valid3 = 3'b111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("n3_ready", int'(in_ready3), 1 << (k % 3));
            q3.push_back('{d: 4'(k % 3 + 5), s: 2'(k % 3)});
            step();
        end
        in_valid3 = 3'b000;
        step();
        step();

        check("n4_queue_drained", q4.size(), 0);
        check("n3_queue_drained", q3.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
